cv32e40px_xif_offload_tracker: RTL and testbench

//  Core-side scoreboard for CV-X-IF offloaded instructions. Logs every accepted

---
 rtl/cv32e40px_xif_offload_tracker_if.sv | 58 +++++
 rtl/cv32e40px_xif_offload_tracker.sv | 217 +++++++++++++++++++++
 tb/tb_cv32e40px_xif_offload_tracker.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40px_xif_offload_tracker_if.sv
// ----------------------------------------------------------------------------
// cv32e40px_xif_offload_tracker_if
//
// Purpose:
//   Bundles the CV-X-IF issue, commit and result handshake signals observed by
//   the offload tracker. The core-side issue logic (or a testbench) drives them
//   through the master modport. The tracker watches them through the slave
//   modport and answers with the issue stall and the result ready.
//
// Signals:
//   issue_valid / issue_ready   issue request handshake
//   issue_id                    id of the instruction being offered
//   issue_accept                coprocessor accepted the instruction
//   issue_wb / issue_dw         accepted instruction writes rd / rd and rd+1
//   issue_stall                 tracker is full; core must hold issue_valid low
//   commit_valid / commit_id    commit strobe and the id it applies to
//   commit_kill                 commit is a kill; no result will follow
//   result_valid / result_id    result offered by the coprocessor
//   result_we                   register write enables (rd, rd+1 if dual-write)
//   result_ready                tracker accepts the result this cycle
// ----------------------------------------------------------------------------
interface cv32e40px_xif_offload_tracker_if #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_DUALWRITE = 1
);
    logic                  issue_valid;
    logic                  issue_ready;
    logic [X_ID_WIDTH-1:0] issue_id;
    logic                  issue_accept;
    logic                  issue_wb;
    logic                  issue_dw;
    logic                  issue_stall;

    logic                  commit_valid;
    logic [X_ID_WIDTH-1:0] commit_id;
    logic                  commit_kill;

    logic                  result_valid;
    logic [X_ID_WIDTH-1:0] result_id;
    logic [X_DUALWRITE:0]  result_we;
    logic                  result_ready;

    // Core / coprocessor side: produces every handshake, sees stall and ready.
    modport master (
        output issue_valid, issue_ready, issue_id, issue_accept, issue_wb, issue_dw,
        output commit_valid, commit_id, commit_kill,
        output result_valid, result_id, result_we,
        input  issue_stall, result_ready
    );

    // Tracker side: observes every handshake, answers with stall and ready.
    modport slave (
        input  issue_valid, issue_ready, issue_id, issue_accept, issue_wb, issue_dw,
        input  commit_valid, commit_id, commit_kill,
        input  result_valid, result_id, result_we,
        output issue_stall, result_ready
    );
endinterface

// File: rtl/cv32e40px_xif_offload_tracker.sv
// ----------------------------------------------------------------------------
// cv32e40px_xif_offload_tracker
//
// Purpose:
//   Core-side scoreboard for CV-X-IF offloaded instructions. Every accepted
//   issue handshake allocates an entry. A commit moves it to COMMITTED, or
//   frees it when the commit is a kill. A result handshake retires a COMMITTED
//   entry. Results that arrive before their commit are back-pressured.
//   Protocol violations produce a one-cycle error pulse and a sticky error
//   code. Further offload is stalled while DEPTH entries are in flight.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   xif            slave view of the issue/commit/result handshakes
//   outstanding_o  registered number of live entries
//   busy_o         outstanding_o != 0
//   err_o          one-cycle error pulse, raised the cycle after the event
//   err_code_o     code of the most recent error; holds until the next error
// ----------------------------------------------------------------------------
module cv32e40px_xif_offload_tracker #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned X_DUALWRITE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    cv32e40px_xif_offload_tracker_if.slave xif,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
    output logic                         busy_o,
    output logic                         err_o,
    output logic [2:0]                   err_code_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_FREE,
        ST_ISSUED,
        ST_COMMITTED
    } entry_state_e;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_DUP_ID      = 3'd1,
        ERR_OVERFLOW    = 3'd2,
        ERR_COMMIT_UNK  = 3'd3,
        ERR_RES_UNKNOWN = 3'd4,
        ERR_WE_MISMATCH = 3'd5
    } err_code_e;

    entry_state_e          state_q [DEPTH];
    logic [X_ID_WIDTH-1:0] id_q    [DEPTH];
    logic                  wb_q    [DEPTH];
    logic                  dw_q    [DEPTH];

    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  err_q;
    err_code_e             err_code_q;

    logic                  full;
    logic                  issue_fire;
    logic                  issue_hit;
    logic                  alloc;
    logic [IW-1:0]         alloc_idx;
    logic                  commit_hit;
    logic [IW-1:0]         commit_idx;
    logic                  commit_ok;
    logic                  free_kill;
    logic                  res_hit;
    logic [IW-1:0]         res_idx;
    logic                  res_committed;
    logic                  res_wb;
    logic                  res_dw;
    logic                  result_ready;
    logic                  result_fire;
    logic                  free_res;
    logic [1:0]            we_pad;
    logic [1:0]            we_exp;
    logic                  err_any;
    err_code_e             err_code_d;

    // Lookups against the registered table only, so same-cycle issue, commit
    // and result all see the old state. Live ids are unique (duplicates are
    // refused), so each lookup matches at most one entry. The free-slot search
    // walks downwards so that the lowest free index is the one that sticks.
    always_comb begin
        full          = (count_q == CW'(DEPTH));
        issue_fire    = xif.issue_valid & xif.issue_ready & xif.issue_accept;
        issue_hit     = 1'b0;
        alloc_idx     = '0;
        commit_hit    = 1'b0;
        commit_idx    = '0;
        res_hit       = 1'b0;
        res_idx       = '0;
        res_committed = 1'b0;
        res_wb        = 1'b0;
        res_dw        = 1'b0;

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (state_q[i] != ST_FREE) begin
                if (id_q[i] == xif.issue_id) begin
                    issue_hit = 1'b1;
                end
                if ((id_q[i] == xif.commit_id) && (state_q[i] == ST_ISSUED)) begin
                    commit_hit = 1'b1;
                    commit_idx = IW'(i);
                end
                if (id_q[i] == xif.result_id) begin
                    res_hit       = 1'b1;
                    res_idx       = IW'(i);
                    res_committed = (state_q[i] == ST_COMMITTED);
                    res_wb        = wb_q[i];
                    res_dw        = dw_q[i];
                end
            end
        end

        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (state_q[i] == ST_FREE) begin
                alloc_idx = IW'(i);
            end
        end
    end

    // Handshake decisions. A result for an ISSUED entry is accepted only when
    // the same entry commits (without kill) in this very cycle. A result whose
    // id matches nothing is accepted and dropped so the coprocessor never hangs.
    always_comb begin
        commit_ok    = xif.commit_valid & ~xif.commit_kill & commit_hit;
        free_kill    = xif.commit_valid &  xif.commit_kill & commit_hit;
        result_ready = ~res_hit | res_committed |
                       (commit_ok & (xif.commit_id == xif.result_id));
        result_fire  = xif.result_valid & result_ready;
        free_res     = result_fire & res_hit;
        alloc        = issue_fire & ~full & ~issue_hit;

        we_pad = 2'(xif.result_we);
        we_exp = {((X_DUALWRITE != 0) ? (res_wb & res_dw) : 1'b0), res_wb};

        count_d = count_q + CW'(alloc) - CW'(free_res) - CW'(free_kill);
    end

    // Error detection, checked lowest code first so the lowest code wins.
    always_comb begin
        err_any    = 1'b1;
        err_code_d = ERR_NONE;
        if (issue_fire & issue_hit) begin
            err_code_d = ERR_DUP_ID;
        end else if (issue_fire & full) begin
            err_code_d = ERR_OVERFLOW;
        end else if (xif.commit_valid & ~commit_hit) begin
            err_code_d = ERR_COMMIT_UNK;
        end else if (xif.result_valid & ~res_hit) begin
            err_code_d = ERR_RES_UNKNOWN;
        end else if (free_res & (we_pad != we_exp)) begin
            err_code_d = ERR_WE_MISMATCH;
        end else begin
            err_any = 1'b0;
        end
    end

    // Entry table. A fresh allocation always lands on a slot that was FREE in
    // the old table, so it never collides with a commit or free of a live
    // entry. A bypassed result frees the entry even though it commits in the
    // same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                state_q[i] <= ST_FREE;
                id_q[i]    <= '0;
                wb_q[i]    <= 1'b0;
                dw_q[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (alloc && (alloc_idx == IW'(i))) begin
                    state_q[i] <= ST_ISSUED;
                    id_q[i]    <= xif.issue_id;
                    wb_q[i]    <= xif.issue_wb;
                    dw_q[i]    <= xif.issue_dw;
                end else if (free_res && (res_idx == IW'(i))) begin
                    state_q[i] <= ST_FREE;
                end else if (free_kill && (commit_idx == IW'(i))) begin
                    state_q[i] <= ST_FREE;
                end else if (commit_ok && (commit_idx == IW'(i))) begin
                    state_q[i] <= ST_COMMITTED;
                end
            end
        end
    end

    // Live count and error reporting. The pulse lasts one cycle; the code is
    // kept until a newer error replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            count_q <= count_d;
            err_q   <= err_any;
            if (err_any) begin
                err_code_q <= err_code_d;
            end
        end
    end

    assign xif.issue_stall  = full;
    assign xif.result_ready = result_ready;
    assign outstanding_o    = count_q;
    assign busy_o           = (count_q != '0);
    assign err_o            = err_q;
    assign err_code_o       = err_code_q;

endmodule

// File: tb/tb_cv32e40px_xif_offload_tracker.sv
// ----------------------------------------------------------------------------
// tb_cv32e40px_xif_offload_tracker
//
// Purpose:
//   Directed test of the X-IF offload tracker. Each table row holds one
//   cycle's stimulus and the outputs expected in that cycle before the next
//   rising edge. The expectations were worked out by hand from the intended
//   behaviour. An asynchronous reset taken mid-operation is exercised
//   separately at the end.
// ----------------------------------------------------------------------------
module tb_cv32e40px_xif_offload_tracker;

    localparam int unsigned X_ID_WIDTH  = 4;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned X_DUALWRITE = 1;
    localparam int          NVEC        = 48;

    logic       clk;
    logic       rst_n;
    logic [2:0] outstanding_o;
    logic       busy_o;
    logic       err_o;
    logic [2:0] err_code_o;

    int n_checks;
    int n_fail;

    cv32e40px_xif_offload_tracker_if #(
        .X_ID_WIDTH (X_ID_WIDTH),
        .X_DUALWRITE(X_DUALWRITE)
    ) xif ();

    cv32e40px_xif_offload_tracker #(
        .X_ID_WIDTH (X_ID_WIDTH),
        .DEPTH      (DEPTH),
        .X_DUALWRITE(X_DUALWRITE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .xif          (xif),
        .outstanding_o(outstanding_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .err_code_o   (err_code_o)
    );

    typedef struct {
        logic       iv;
        logic       ir;
        logic [3:0] iid;
        logic       acc;
        logic       wb;
        logic       dw;
        logic       cv;
        logic [3:0] cid;
        logic       kill;
        logic       rv;
        logic [3:0] rid;
        logic [1:0] we;
        logic       e_stall;
        logic       e_ready;
        logic [2:0] e_out;
        logic       e_err;
        logic [2:0] e_code;
    } vec_t;

    vec_t vecs [NVEC];

    // Free-running clock; inputs change on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input int iv, input int ir, input int iid, input int acc,
                                input int wb, input int dw, input int cv, input int cid,
                                input int kill, input int rv, input int rid, input int we,
                                input int es, input int er, input int eo, input int ee,
                                input int ec);
        vec_t v;
        v.iv      = iv[0];
        v.ir      = ir[0];
        v.iid     = iid[3:0];
        v.acc     = acc[0];
        v.wb      = wb[0];
        v.dw      = dw[0];
        v.cv      = cv[0];
        v.cid     = cid[3:0];
        v.kill    = kill[0];
        v.rv      = rv[0];
        v.rid     = rid[3:0];
        v.we      = we[1:0];
        v.e_stall = es[0];
        v.e_ready = er[0];
        v.e_out   = eo[2:0];
        v.e_err   = ee[0];
        v.e_code  = ec[2:0];
        return v;
    endfunction

    // Drive one cycle of stimulus on the falling edge, then let it settle.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        xif.issue_valid  = v.iv;
        xif.issue_ready  = v.ir;
        xif.issue_id     = v.iid;
        xif.issue_accept = v.acc;
        xif.issue_wb     = v.wb;
        xif.issue_dw     = v.dw;
        xif.commit_valid = v.cv;
        xif.commit_id    = v.cid;
        xif.commit_kill  = v.kill;
        xif.result_valid = v.rv;
        xif.result_id    = v.rid;
        xif.result_we    = v.we;
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Columns: iv ir iid acc wb dw | cv cid kill | rv rid we || stall ready out err code
        vecs[0]  = mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 0,1,0,0,0); // idle after reset
        vecs[1]  = mk(1,1, 3,1,1,0, 0,0,0, 0,15,0, 0,1,0,0,0); // issue id3
        vecs[2]  = mk(0,1, 0,0,0,0, 1,3,0, 0,15,0, 0,1,1,0,0); // commit id3
        vecs[3]  = mk(0,1, 0,0,0,0, 0,0,0, 1, 3,1, 0,1,1,0,0); // result id3 we=01
        vecs[4]  = mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 0,1,0,0,0);
        vecs[5]  = mk(1,1, 5,1,1,0, 0,0,0, 0,15,0, 0,1,0,0,0); // issue id5
        vecs[6]  = mk(0,1, 0,0,0,0, 0,0,0, 1, 5,1, 0,0,1,0,0); // result before commit
        vecs[7]  = mk(0,1, 0,0,0,0, 0,0,0, 1, 5,1, 0,0,1,0,0);
        vecs[8]  = mk(0,1, 0,0,0,0, 0,0,0, 1, 5,1, 0,0,1,0,0);
        vecs[9]  = mk(0,1, 0,0,0,0, 1,5,0, 1, 5,1, 0,1,1,0,0); // commit bypass
        vecs[10] = mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 0,1,0,0,0); // freed
        vecs[11] = mk(1,1, 0,1,1,0, 0,0,0, 0,15,0, 0,1,0,0,0); // fill 0..3
        vecs[12] = mk(1,1, 1,1,1,0, 0,0,0, 0,15,0, 0,1,1,0,0);
        vecs[13] = mk(1,1, 2,1,1,0, 0,0,0, 0,15,0, 0,1,2,0,0);
        vecs[14] = mk(1,1, 3,1,1,0, 0,0,0, 0,15,0, 0,1,3,0,0);
        vecs[15] = mk(0,1, 0,0,0,0, 1,0,0, 0,15,0, 1,1,4,0,0); // full, commit id0
        vecs[16] = mk(1,1, 4,1,1,0, 0,0,0, 1, 0,1, 1,1,4,0,0); // free id0 + overflow id4
        vecs[17] = mk(1,1, 4,1,1,0, 0,0,0, 0,15,0, 0,1,3,1,2); // stall lifted, issue id4
        vecs[18] = mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 1,1,4,0,2);
        vecs[19] = mk(0,1, 0,0,0,0, 1,1,1, 0,15,0, 1,1,4,0,2); // kill ids 1..4
        vecs[20] = mk(0,1, 0,0,0,0, 1,2,1, 0,15,0, 0,1,3,0,2);
        vecs[21] = mk(0,1, 0,0,0,0, 1,3,1, 0,15,0, 0,1,2,0,2);
        vecs[22] = mk(0,1, 0,0,0,0, 1,4,1, 0,15,0, 0,1,1,0,2);
        vecs[23] = mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 0,1,0,0,2);
        vecs[24] = mk(1,1, 2,1,1,0, 0,0,0, 0,15,0, 0,1,0,0,2); // issue id2
        vecs[25] = mk(0,1, 0,0,0,0, 1,2,1, 0,15,0, 0,1,1,0,2); // kill id2
        vecs[26] = mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 0,1,0,0,2);
        vecs[27] = mk(0,1, 0,0,0,0, 0,0,0, 1, 2,1, 0,1,0,0,2); // stray result id2
        vecs[28] = mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 0,1,0,1,4);
        vecs[29] = mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 0,1,0,0,4);
        vecs[30] = mk(1,1, 1,1,1,0, 0,0,0, 0,15,0, 0,1,0,0,4); // issue id1
        vecs[31] = mk(1,1, 1,1,1,0, 0,0,0, 0,15,0, 0,1,1,0,4); // duplicate id1
        vecs[32] = mk(0,1, 0,0,0,0, 1,1,0, 0,15,0, 0,1,1,1,1); // commit id1
        vecs[33] = mk(0,1, 0,0,0,0, 0,0,0, 1, 1,3, 0,1,1,0,1); // we=11, wb=1 dw=0
        vecs[34] = mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 0,1,0,1,5);
        vecs[35] = mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 0,1,0,0,5);
        vecs[36] = mk(0,1, 0,0,0,0, 1,7,0, 1, 9,1, 0,1,0,0,5); // codes 3 and 4 together
        vecs[37] = mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 0,1,0,1,3);
        vecs[38] = mk(1,1, 6,1,1,1, 0,0,0, 0,15,0, 0,1,0,0,3); // dual-write id6
        vecs[39] = mk(0,1, 0,0,0,0, 1,6,0, 0,15,0, 0,1,1,0,3);
        vecs[40] = mk(0,1, 0,0,0,0, 0,0,0, 1, 6,3, 0,1,1,0,3); // we=11 correct
        vecs[41] = mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 0,1,0,0,3);
        vecs[42] = mk(1,1, 8,0,1,0, 0,0,0, 0,15,0, 0,1,0,0,3); // accept=0 ignored
        vecs[43] = mk(1,0, 8,1,1,0, 0,0,0, 0,15,0, 0,1,0,0,3); // no issue_ready
        vecs[44] = mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 0,1,0,0,3);
        vecs[45] = mk(1,1, 9,1,1,0, 1,9,0, 0,15,0, 0,1,0,0,3); // issue+commit id9
        vecs[46] = mk(0,1, 0,0,0,0, 1,9,1, 0,15,0, 0,1,1,1,3); // kill id9
        vecs[47] = mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 0,1,0,0,3);

        rst_n = 1'b0;
        xif.issue_valid  = 1'b0;
        xif.issue_ready  = 1'b1;
        xif.issue_id     = '0;
        xif.issue_accept = 1'b0;
        xif.issue_wb     = 1'b0;
        xif.issue_dw     = 1'b0;
        xif.commit_valid = 1'b0;
        xif.commit_id    = '0;
        xif.commit_kill  = 1'b0;
        xif.result_valid = 1'b0;
        xif.result_id    = 4'd15;
        xif.result_we    = '0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset.outstanding", int'(outstanding_o), 0);
        checkOutput("reset.busy", int'(busy_o), 0);
        checkOutput("reset.stall", int'(xif.issue_stall), 0);
        checkOutput("reset.err", int'(err_o), 0);
        checkOutput("reset.err_code", int'(err_code_o), 0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d.stall", i), int'(xif.issue_stall), int'(vecs[i].e_stall));
            checkOutput($sformatf("v%0d.ready", i), int'(xif.result_ready), int'(vecs[i].e_ready));
            checkOutput($sformatf("v%0d.outstanding", i), int'(outstanding_o), int'(vecs[i].e_out));
            checkOutput($sformatf("v%0d.busy", i), int'(busy_o), (vecs[i].e_out != 3'd0) ? 1 : 0);
            checkOutput($sformatf("v%0d.err", i), int'(err_o), int'(vecs[i].e_err));
            checkOutput($sformatf("v%0d.err_code", i), int'(err_code_o), int'(vecs[i].e_code));
        end

        // Asynchronous reset with three entries live and a result held back.
        applyStimulus(mk(1,1,10,1,1,0, 0,0,0, 0,15,0, 0,0,0,0,0));
        applyStimulus(mk(1,1,11,1,1,0, 0,0,0, 0,15,0, 0,0,0,0,0));
        applyStimulus(mk(1,1,12,1,1,0, 0,0,0, 0,15,0, 0,0,0,0,0));
        applyStimulus(mk(0,1, 0,0,0,0, 0,0,0, 1,10,1, 0,0,0,0,0));
        checkOutput("arst.pre_outstanding", int'(outstanding_o), 3);
        checkOutput("arst.pre_ready", int'(xif.result_ready), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst.outstanding", int'(outstanding_o), 0);
        checkOutput("arst.busy", int'(busy_o), 0);
        checkOutput("arst.stall", int'(xif.issue_stall), 0);
        checkOutput("arst.err", int'(err_o), 0);
        applyStimulus(mk(0,1, 0,0,0,0, 0,0,0, 0,15,0, 0,0,0,0,0));
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("post_rst%0d.err", k), int'(err_o), 0);
            checkOutput($sformatf("post_rst%0d.err_code", k), int'(err_code_o), 0);
            checkOutput($sformatf("post_rst%0d.outstanding", k), int'(outstanding_o), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
